// File: rtl/axis_fifo_pkg.sv
// ---------------------------------------------------------------------------
// axis_fifo_pkg
// Shared helpers for the parametrised AXI4-Stream FIFO.
//   clog2_f       : constant-foldable ceil(log2(value)), usable in port widths
//   DEF_*         : default geometry of the FIFO (16 x 8-bit stream beats)
//   beat_w_f      : packed width of one stored beat {last, keep, data}
//   axis_beat_def_t : beat layout for the default geometry
// Modules with other geometries build their own axis_beat_t from their
// parameters with the same field order.
// ---------------------------------------------------------------------------
package axis_fifo_pkg;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int beat_w_f(input int data_w, input int keep_w);
    return 1 + keep_w + data_w;
  endfunction

  localparam int DEF_DATA_W = 8;
  localparam int DEF_KEEP_W = DEF_DATA_W / 8;
  localparam int DEF_DEPTH  = 16;
  localparam int ADDR_W     = clog2_f(DEF_DEPTH);
  localparam int PTR_W      = ADDR_W + 1;

  typedef struct packed {
    logic                  last;
    logic [DEF_KEEP_W-1:0] keep;
    logic [DEF_DATA_W-1:0] data;
  } axis_beat_def_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// ---------------------------------------------------------------------------
// axis_fifo_mem
// DEPTH x BEAT_W storage array: synchronous write, asynchronous read.
// The array has no reset; validity of entries is tracked by the pointers in
// the parent.
//   Aclk    : clock, write on rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (combinational read)
//   rdata_o : read data
// ---------------------------------------------------------------------------
module axis_fifo_mem
  import axis_fifo_pkg::*;
#(
  parameter int BEAT_W = 10,
  parameter int DEPTH  = 16
) (
  input  logic                        Aclk,
  input  logic                        we_i,
  input  logic [clog2_f(DEPTH)-1:0]   waddr_i,
  input  logic [BEAT_W-1:0]           wdata_i,
  input  logic [clog2_f(DEPTH)-1:0]   raddr_i,
  output logic [BEAT_W-1:0]           rdata_o
);

  logic [BEAT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge Aclk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo_param.sv
// ---------------------------------------------------------------------------
// axis_fifo_param
// AXI4-Stream FIFO, first-word-fall-through, with fill-level status and an
// optional store-and-forward packet mode.
//
// Handshake: a beat moves on a rising Aclk edge when valid && ready on that
// interface; valid never depends combinationally on ready; once
// m_axis_tvalid is high it and the head beat hold until the pop.
//
// Ports
//   Aclk, Areset_n            : clock, asynchronous active-low reset
//   s_axis_t{valid,ready,data,keep,last} : upstream slave stream
//   m_axis_t{valid,ready,data,keep,last} : downstream master stream
//   level                     : stored beat count, 0..DEPTH
//   full, empty               : level == DEPTH / level == 0
//   pkt_cnt                   : stored beats carrying tlast
// ---------------------------------------------------------------------------
module axis_fifo_param
  import axis_fifo_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int KEEP_W      = DATA_W / 8,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                      Aclk,
  input  logic                      Areset_n,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [DATA_W-1:0]         s_axis_tdata,
  input  logic [KEEP_W-1:0]         s_axis_tkeep,
  input  logic                      s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic [KEEP_W-1:0]         m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [clog2_f(DEPTH):0]   level,
  output logic                      full,
  output logic                      empty,
  output logic [clog2_f(DEPTH):0]   pkt_cnt
);

  localparam int ADDR_W = clog2_f(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } axis_beat_t;

  localparam int BEAT_W = $bits(axis_beat_t);

  logic             rst_done_q;
  logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
  logic [PTR_W-1:0] r_ptr_q, r_ptr_d;
  logic [PTR_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic             release_q, release_d;

  axis_beat_t wr_beat;
  axis_beat_t rd_beat;

  logic full_w, empty_w, m_valid_w;
  logic push, pop, push_last, pop_last;

  // Pointer-based flags: the extra MSB distinguishes full from empty when
  // the address bits match.
  assign empty_w = (w_ptr_q == r_ptr_q);
  assign full_w  = (w_ptr_q[ADDR_W-1:0] == r_ptr_q[ADDR_W-1:0]) &&
                   (w_ptr_q[ADDR_W] != r_ptr_q[ADDR_W]);

  // In packet mode the head is only offered once a whole packet is stored,
  // or when a packet is too long to ever fit (release) to avoid deadlock.
  assign m_valid_w = (PACKET_MODE != 0) ?
                     (!empty_w && ((pkt_cnt_q != '0) || release_q)) :
                     !empty_w;

  assign push      = s_axis_tvalid && s_axis_tready;
  assign pop       = m_valid_w && m_axis_tready;
  assign push_last = push && s_axis_tlast;
  assign pop_last  = pop && rd_beat.last;

  assign wr_beat = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  axis_fifo_mem #(
    .BEAT_W (BEAT_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .Aclk    (Aclk),
    .we_i    (push),
    .waddr_i (w_ptr_q[ADDR_W-1:0]),
    .wdata_i (wr_beat),
    .raddr_i (r_ptr_q[ADDR_W-1:0]),
    .rdata_o (rd_beat)
  );

  always_comb begin
    w_ptr_d   = w_ptr_q;
    r_ptr_d   = r_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    release_d = release_q;

    if (push) w_ptr_d = w_ptr_q + PTR_W'(1);
    if (pop)  r_ptr_d = r_ptr_q + PTR_W'(1);

    case ({push_last, pop_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_W'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_W'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    // A full FIFO with no complete packet can only drain by forwarding the
    // partial packet; stay in that state until its tlast leaves.
    if (pop_last)                          release_d = 1'b0;
    else if (full_w && (pkt_cnt_q == '0))  release_d = 1'b1;
  end

  always_ff @(posedge Aclk or negedge Areset_n) begin
    if (!Areset_n) begin
      rst_done_q <= 1'b0;
      w_ptr_q    <= '0;
      r_ptr_q    <= '0;
      pkt_cnt_q  <= '0;
      release_q  <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      w_ptr_q    <= w_ptr_d;
      r_ptr_q    <= r_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      release_q  <= release_d;
    end
  end

  assign s_axis_tready = !full_w && rst_done_q;
  assign m_axis_tvalid = m_valid_w;
  assign m_axis_tdata  = m_valid_w ? rd_beat.data : '0;
  assign m_axis_tkeep  = m_valid_w ? rd_beat.keep : '0;
  assign m_axis_tlast  = m_valid_w ? rd_beat.last : 1'b0;

  assign level   = w_ptr_q - r_ptr_q;
  assign full    = full_w;
  assign empty   = empty_w;
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_axis_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_axis_fifo_param
// Two instances (cut-through = 0, packet mode = 1) of a 16 x 8-bit FIFO.
// Each has a queue model updated on the clock edge; one compare process
// checks every output of both instances on each falling edge.
// ---------------------------------------------------------------------------
module tb_axis_fifo_param;

  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals (index = PACKET_MODE) ----------------
  logic       s_tvalid [2];
  logic       s_tready [2];
  logic [7:0] s_tdata  [2];
  logic [0:0] s_tkeep  [2];
  logic       s_tlast  [2];
  logic       m_tvalid [2];
  logic       m_tready [2];
  logic [7:0] m_tdata  [2];
  logic [0:0] m_tkeep  [2];
  logic       m_tlast  [2];
  logic [4:0] level    [2];
  logic       full     [2];
  logic       empty    [2];
  logic [4:0] pkt_cnt  [2];

  // ---------------- model outputs ----------------
  int         exp_level  [2];
  int         exp_pkt    [2];
  bit         exp_tready [2];
  bit         exp_mvalid [2];
  logic [9:0] exp_head   [2];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [9:0] src_q[$];

  generate
    for (genvar g = 0; g < 2; g++) begin : g_inst
      axis_fifo_param #(
        .DATA_W      (8),
        .KEEP_W      (1),
        .DEPTH       (DEPTH),
        .PACKET_MODE (g)
      ) dut (
        .Aclk          (clk),
        .Areset_n      (rst_n),
        .s_axis_tvalid (s_tvalid[g]),
        .s_axis_tready (s_tready[g]),
        .s_axis_tdata  (s_tdata[g]),
        .s_axis_tkeep  (s_tkeep[g]),
        .s_axis_tlast  (s_tlast[g]),
        .m_axis_tvalid (m_tvalid[g]),
        .m_axis_tready (m_tready[g]),
        .m_axis_tdata  (m_tdata[g]),
        .m_axis_tkeep  (m_tkeep[g]),
        .m_axis_tlast  (m_tlast[g]),
        .level         (level[g]),
        .full          (full[g]),
        .empty         (empty[g]),
        .pkt_cnt       (pkt_cnt[g])
      );

      // Model: a queue of stored beats {last, keep, data}.
      initial begin : model
        logic [9:0] q[$];
        bit rel, rdone, push, pop, nrel;
        int lasts;
        rel = 0;
        rdone = 0;
        forever begin
          @(posedge clk or negedge rst_n);
          if (!rst_n) begin
            q.delete();
            rel = 0;
            rdone = 0;
          end else begin
            lasts = 0;
            foreach (q[k]) lasts += int'(q[k][9]);
            push = s_tvalid[g] && rdone && (q.size() < DEPTH);
            pop  = exp_mvalid[g] && m_tready[g];
            nrel = rel;
            if (pop && q[0][9]) nrel = 0;
            else if ((q.size() == DEPTH) && (lasts == 0)) nrel = 1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back({s_tlast[g], s_tkeep[g], s_tdata[g]});
            rel = nrel;
            rdone = 1;
          end
          lasts = 0;
          foreach (q[k]) lasts += int'(q[k][9]);
          exp_level[g]  = q.size();
          exp_pkt[g]    = lasts;
          exp_tready[g] = rdone && (q.size() < DEPTH);
          exp_mvalid[g] = (q.size() > 0) && ((g == 0) || (lasts > 0) || rel);
          if (exp_mvalid[g]) exp_head[g] = q[0];
          else               exp_head[g] = '0;
        end
      end
    end
  endgenerate

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string nm, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp)
      $display("FAIL %s inst%0d t=%0t: got 0x%0h expected 0x%0h",
               nm, inst, $time, act, exp);
    else
      pass_cnt++;
  endtask

  // Compare process: every output of both instances on every falling edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("s_tready", i, 32'(s_tready[i]), 32'(exp_tready[i]));
        check("m_tvalid", i, 32'(m_tvalid[i]), 32'(exp_mvalid[i]));
        check("m_tdata",  i, 32'(m_tdata[i]),  32'(exp_head[i][7:0]));
        check("m_tkeep",  i, 32'(m_tkeep[i]),  32'(exp_head[i][8]));
        check("m_tlast",  i, 32'(m_tlast[i]),  32'(exp_head[i][9]));
        check("level",    i, 32'(level[i]),    32'(exp_level[i]));
        check("full",     i, 32'(full[i]),     32'(exp_level[i] == DEPTH));
        check("empty",    i, 32'(empty[i]),    32'(exp_level[i] == 0));
        check("pkt_cnt",  i, 32'(pkt_cnt[i]),  32'(exp_pkt[i]));
      end
    end
  end

  // ---------------- driver ----------------
  // Sends src_q on instance inst; valid held until accepted. With drain set,
  // keeps going until the model reports the FIFO empty.
  task automatic run(input int inst, input int vpct, input int rpct,
                     input bit drain, input int max_cyc, output int ncyc);
    bit hold, v, done;
    hold = 0;
    done = 0;
    ncyc = 0;
    while (!done) begin
      @(negedge clk);
      #1;
      if (src_q.size() == 0 && (!drain || exp_level[inst] == 0)) begin
        done = 1;
      end else if (ncyc == max_cyc) begin
        chk_cnt++;
        $display("FAIL timeout inst%0d: got %0d cycles expected under %0d",
                 inst, ncyc, max_cyc);
        done = 1;
      end else begin
        v = (src_q.size() > 0) && (hold || (int'($urandom_range(99)) < vpct));
        s_tvalid[inst] = v;
        if (v) {s_tlast[inst], s_tkeep[inst], s_tdata[inst]} = src_q[0];
        m_tready[inst] = int'($urandom_range(99)) < rpct;
        hold = v && !s_tready[inst];
        if (v && s_tready[inst]) void'(src_q.pop_front());
        ncyc++;
      end
    end
    s_tvalid[inst] = 1'b0;
    m_tready[inst] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    for (int i = 0; i < 2; i++) begin
      s_tvalid[i] = 0; s_tdata[i] = '0; s_tkeep[i] = '0;
      s_tlast[i] = 0;  m_tready[i] = 0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset with upstream valid held high.
    for (int i = 0; i < 2; i++) begin
      s_tvalid[i] = 1; s_tdata[i] = 8'hA5; s_tkeep[i] = 1'b1; s_tlast[i] = 1;
    end
    repeat (3) @(negedge clk);
    #1;
    check("rst_tready", 0, 32'(s_tready[0]), 32'd0);
    check("rst_empty",  0, 32'(empty[0]),    32'd1);
    check("rst_level",  0, 32'(level[0]),    32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("first_tready", 0, 32'(s_tready[0]), 32'd1);
    check("first_level",  0, 32'(level[0]),    32'd0);
    @(negedge clk); #1;
    check("first_push",   0, 32'(level[0]),    32'd1);
    check("first_push_pk",1, 32'(m_tvalid[1]), 32'd1);
    for (int i = 0; i < 2; i++) begin
      s_tvalid[i] = 0; s_tlast[i] = 0; m_tready[i] = 1;
    end
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) m_tready[i] = 0;
    check("first_pop", 0, 32'(empty[0]), 32'd1);

    // Fill and drain, cut-through.
    for (int k = 0; k < 16; k++) src_q.push_back({1'b0, 1'b1, 8'(k)});
    run(0, 100, 0, 0, 100, n);
    check("fill_full",   0, 32'(full[0]),     32'd1);
    check("fill_tready", 0, 32'(s_tready[0]), 32'd0);
    check("fill_level",  0, 32'(level[0]),    32'd16);
    check("fill_head",   0, 32'(m_tdata[0]),  32'h00);
    run(0, 100, 100, 1, 100, n);
    check("drain_empty", 0, 32'(empty[0]),    32'd1);

    // Streaming, 40 beats, both sides always ready: one beat per cycle.
    for (int k = 0; k < 40; k++) begin
      logic kp;
      kp = (k % 3 == 0) ? 1'b0 : (k % 3 == 1) ? 1'b1 : 1'($urandom_range(1));
      src_q.push_back({1'(k % 8 == 7), kp, 8'(k * 7 + 3)});
    end
    run(0, 100, 100, 1, 200, n);
    check("stream_cycles", 0, 32'(n), 32'd41);

    // Random backpressure, cut-through.
    for (int k = 0; k < 2000; k++)
      src_q.push_back(10'($urandom_range(1023)));
    run(0, 50, 50, 1, 20000, n);

    // Packet mode, 5-beat packet.
    for (int k = 1; k <= 4; k++) src_q.push_back({1'b0, 1'b1, 8'(k)});
    run(1, 100, 0, 0, 100, n);
    check("pk4_tvalid", 1, 32'(m_tvalid[1]), 32'd0);
    check("pk4_level",  1, 32'(level[1]),    32'd4);
    src_q.push_back({1'b1, 1'b1, 8'd5});
    run(1, 100, 0, 0, 100, n);
    check("pk5_tvalid", 1, 32'(m_tvalid[1]), 32'd1);
    check("pk5_pktcnt", 1, 32'(pkt_cnt[1]),  32'd1);
    check("pk5_head",   1, 32'(m_tdata[1]),  32'd1);
    run(1, 100, 100, 1, 100, n);

    // Packet mode, 20-beat packet longer than DEPTH.
    for (int k = 0; k < 16; k++) src_q.push_back({1'b0, 1'b0, 8'(8'h20 + k)});
    run(1, 100, 0, 0, 100, n);
    check("pk20_full",   1, 32'(full[1]),     32'd1);
    check("pk20_hold",   1, 32'(m_tvalid[1]), 32'd0);
    @(negedge clk); #1;
    check("pk20_rel",    1, 32'(m_tvalid[1]), 32'd1);
    check("pk20_head",   1, 32'(m_tdata[1]),  32'h20);
    for (int k = 16; k < 20; k++)
      src_q.push_back({1'(k == 19), 1'b0, 8'(8'h20 + k)});
    run(1, 100, 100, 1, 100, n);
    src_q.push_back({1'b0, 1'b1, 8'h55});
    run(1, 100, 0, 0, 100, n);
    check("pk20_relclr", 1, 32'(m_tvalid[1]), 32'd0);
    src_q.push_back({1'b1, 1'b1, 8'h56});
    run(1, 100, 100, 1, 100, n);

    // Random backpressure, packet mode.
    for (int k = 0; k < 300; k++)
      src_q.push_back({1'(k == 299 || $urandom_range(3) == 0),
                       1'($urandom_range(1)), 8'($urandom_range(255))});
    run(1, 50, 50, 1, 5000, n);

    // Mid-operation reset with level 7, two packets stored.
    for (int k = 0; k < 7; k++)
      src_q.push_back({1'(k == 2 || k == 6), 1'b1, 8'(8'hC0 + k)});
    run(0, 100, 0, 0, 100, n);
    check("mr_level",  0, 32'(level[0]),   32'd7);
    check("mr_pkt",    0, 32'(pkt_cnt[0]), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mr_tready", 0, 32'(s_tready[0]), 32'd0);
    check("mr_tvalid", 0, 32'(m_tvalid[0]), 32'd0);
    check("mr_tdata",  0, 32'(m_tdata[0]),  32'd0);
    check("mr_tlast",  0, 32'(m_tlast[0]),  32'd0);
    check("mr_level0", 0, 32'(level[0]),    32'd0);
    check("mr_empty",  0, 32'(empty[0]),    32'd1);
    check("mr_full",   0, 32'(full[0]),     32'd0);
    check("mr_pkt0",   0, 32'(pkt_cnt[0]),  32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("mr_noold",  0, 32'(m_tvalid[0]), 32'd0);
    src_q.push_back({1'b1, 1'b1, 8'h99});
    run(0, 100, 0, 0, 100, n);
    check("mr_fresh",  0, 32'(m_tdata[0]),  32'h99);
    run(0, 100, 100, 1, 100, n);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
